// File: rtl/dispense_sequencer.sv
// Dispense sequencer: primes the outlet, pours a latched number of units on a
// fixed tick base, then drains, reporting completion or abort with a pulse.
module dispense_sequencer #(
    parameter int AMOUNT_WIDTH   = 8,
    parameter int TICKS_PER_UNIT = 50,
    parameter int PRIME_CYCLES   = 4,
    parameter int CLOSE_CYCLES   = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [AMOUNT_WIDTH-1:0] amount,
    input  logic                    cancel,
    output logic                    valve_open,
    output logic                    pump_on,
    output logic                    busy,
    output logic                    done,
    output logic                    aborted,
    output logic [AMOUNT_WIDTH-1:0] dispensed,
    output logic [AMOUNT_WIDTH-1:0] remaining
);

    localparam int CNT_MAX = (PRIME_CYCLES > CLOSE_CYCLES) ? PRIME_CYCLES : CLOSE_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int TW      = $clog2(TICKS_PER_UNIT + 1);

    localparam logic [CW-1:0] PRIME_LAST = CW'(PRIME_CYCLES - 1);
    localparam logic [CW-1:0] CLOSE_LAST = CW'(CLOSE_CYCLES - 1);
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICKS_PER_UNIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        POUR,
        CLOSE
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_phaseCnt;
    logic [TW-1:0]   r_tick;
    logic            r_abort;

    // Completion on the last terminal tick takes precedence over a coincident cancel.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_phaseCnt <= '0;
            r_tick     <= '0;
            r_abort    <= 1'b0;
            valve_open <= 1'b0;
            pump_on    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            dispensed  <= '0;
            remaining  <= '0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && (amount != '0)) begin
                        r_state    <= PRIME;
                        r_phaseCnt <= '0;
                        r_abort    <= 1'b0;
                        remaining  <= amount;
                        dispensed  <= '0;
                        valve_open <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                PRIME: begin
                    if (cancel) begin
                        r_state    <= CLOSE;
                        r_phaseCnt <= '0;
                        r_abort    <= 1'b1;
                    end else if (r_phaseCnt == PRIME_LAST) begin
                        r_state <= POUR;
                        r_tick  <= '0;
                        pump_on <= 1'b1;
                    end else begin
                        r_phaseCnt <= r_phaseCnt + CW'(1);
                    end
                end
                POUR: begin
                    if (r_tick == TICK_LAST) begin
                        r_tick    <= '0;
                        dispensed <= dispensed + AMOUNT_WIDTH'(1);
                        remaining <= remaining - AMOUNT_WIDTH'(1);
                        if (remaining == AMOUNT_WIDTH'(1)) begin
                            r_state    <= CLOSE;
                            r_phaseCnt <= '0;
                            pump_on    <= 1'b0;
                        end else if (cancel) begin
                            r_state    <= CLOSE;
                            r_phaseCnt <= '0;
                            r_abort    <= 1'b1;
                            pump_on    <= 1'b0;
                        end
                    end else if (cancel) begin
                        r_state    <= CLOSE;
                        r_phaseCnt <= '0;
                        r_abort    <= 1'b1;
                        pump_on    <= 1'b0;
                    end else begin
                        r_tick <= r_tick + TW'(1);
                    end
                end
                CLOSE: begin
                    if (r_phaseCnt == CLOSE_LAST) begin
                        r_state    <= IDLE;
                        valve_open <= 1'b0;
                        busy       <= 1'b0;
                        done       <= !r_abort;
                        aborted    <= r_abort;
                    end else begin
                        r_phaseCnt <= r_phaseCnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dispense_sequencer.sv
// Bench for dispense_sequencer: a timeline model predicts every output each
// cycle, plus literal expectations per directed scenario.
module tb_dispense_sequencer;

    localparam int AW = 8;
    localparam int T  = 4;
    localparam int P  = 2;
    localparam int C  = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] amount;
    logic          cancel;
    logic          valve_open;
    logic          pump_on;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [AW-1:0] dispensed;
    logic [AW-1:0] remaining;

    int passCount  = 0;
    int totalCount = 0;

    int valveCnt = 0;
    int pumpCnt  = 0;
    int doneCnt  = 0;
    int abortCnt = 0;

    bit modelReady = 0;
    int edgeIdx    = 0;
    bit seqValid   = 0;
    int seqStart   = 0;
    int seqAmount  = 0;
    int fullEnd    = 0;
    int pourEnd    = 0;
    int closeEnd   = 0;
    bit seqAbort   = 0;

    int expValve, expPump, expBusy, expDone, expAbort, expDisp, expRem;

    dispense_sequencer #(
        .AMOUNT_WIDTH  (AW),
        .TICKS_PER_UNIT(T),
        .PRIME_CYCLES  (P),
        .CLOSE_CYCLES  (C)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .amount    (amount),
        .cancel    (cancel),
        .valve_open(valve_open),
        .pump_on   (pump_on),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .dispensed (dispensed),
        .remaining (remaining)
    );

    always #5 clock = ~clock;

    function automatic bit busyAt(int t);
        return seqValid && (t > seqStart) && (t <= closeEnd);
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        totalCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    endtask

    task automatic applyStimulus(input bit st, input int amt, input bit cn, input bit rs, input int n);
        start  = st;
        amount = AW'(amt);
        cancel = cn;
        reset  = rs;
        repeat (n) @(negedge clock);
        #1;
    endtask

    task automatic clearCounts();
        valveCnt = 0;
        pumpCnt  = 0;
        doneCnt  = 0;
        abortCnt = 0;
    endtask

    // Model: each accepted start defines a timeline of prime, pour and close
    // windows; a cancel truncates the pour window at the edge it is sampled.
    initial begin
        forever begin
            @(posedge clock);
            edgeIdx++;
            if (!reset) begin
                seqValid = 0;
            end else if (!busyAt(edgeIdx)) begin
                if (start && amount != '0) begin
                    seqValid  = 1;
                    seqStart  = edgeIdx;
                    seqAmount = int'(amount);
                    fullEnd   = seqStart + P + seqAmount * T;
                    pourEnd   = fullEnd;
                    closeEnd  = pourEnd + C;
                    seqAbort  = 0;
                end
            end else if (cancel && edgeIdx <= pourEnd && edgeIdx != fullEnd) begin
                pourEnd  = edgeIdx;
                closeEnd = edgeIdx + C;
                seqAbort = 1;
            end
            begin
                int t;
                int lim;
                t        = edgeIdx + 1;
                expBusy  = busyAt(t);
                expValve = expBusy;
                expPump  = seqValid && (t > seqStart + P) && (t <= pourEnd);
                expDone  = seqValid && !seqAbort && (t == closeEnd + 1);
                expAbort = seqValid && seqAbort && (t == closeEnd + 1);
                if (seqValid) begin
                    lim     = (t - 1 < pourEnd) ? t - 1 : pourEnd;
                    expDisp = lim - (seqStart + P);
                    expDisp = (expDisp < 0) ? 0 : expDisp / T;
                    if (expDisp > seqAmount) expDisp = seqAmount;
                    expRem  = seqAmount - expDisp;
                end else begin
                    expDisp = 0;
                    expRem  = 0;
                end
            end
            modelReady = 1;
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (modelReady) begin
                checkOutput("valve_open", int'(valve_open), expValve);
                checkOutput("pump_on",    int'(pump_on),    expPump);
                checkOutput("busy",       int'(busy),       expBusy);
                checkOutput("done",       int'(done),       expDone);
                checkOutput("aborted",    int'(aborted),    expAbort);
                checkOutput("dispensed",  int'(dispensed),  expDisp);
                checkOutput("remaining",  int'(remaining),  expRem);
                valveCnt += int'(valve_open);
                pumpCnt  += int'(pump_on);
                doneCnt  += int'(done);
                abortCnt += int'(aborted);
            end
        end
    end

    initial begin
        reset  = 1'b0;
        start  = 1'b0;
        amount = '0;
        cancel = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        checkOutput("rst_valve",     int'(valve_open), 0);
        checkOutput("rst_busy",      int'(busy),       0);
        checkOutput("rst_dispensed", int'(dispensed),  0);
        checkOutput("rst_remaining", int'(remaining),  0);

        $display("[TB] scenario 1: normal dispense");
        applyStimulus(0, 0, 0, 1, 1);
        clearCounts();
        applyStimulus(1, 3, 0, 1, 1);
        applyStimulus(0, 0, 0, 1, 22);
        checkOutput("s1_valve_cycles", valveCnt, 17);
        checkOutput("s1_pump_cycles",  pumpCnt,  12);
        checkOutput("s1_done_pulses",  doneCnt,  1);
        checkOutput("s1_abort_pulses", abortCnt, 0);
        checkOutput("s1_dispensed",    int'(dispensed), 3);
        checkOutput("s1_remaining",    int'(remaining), 0);

        $display("[TB] scenario 2: zero amount");
        clearCounts();
        applyStimulus(1, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 1, 5);
        checkOutput("s2_valve_cycles", valveCnt, 0);
        checkOutput("s2_pulses",       doneCnt + abortCnt, 0);
        checkOutput("s2_dispensed",    int'(dispensed), 3);

        $display("[TB] scenario 3: cancel mid-pour");
        clearCounts();
        applyStimulus(1, 5, 0, 1, 1);
        applyStimulus(0, 0, 0, 1, 7);
        applyStimulus(0, 0, 1, 1, 1);
        applyStimulus(0, 0, 0, 1, 6);
        checkOutput("s3_valve_cycles", valveCnt, 11);
        checkOutput("s3_pump_cycles",  pumpCnt,  6);
        checkOutput("s3_abort_pulses", abortCnt, 1);
        checkOutput("s3_done_pulses",  doneCnt,  0);
        checkOutput("s3_dispensed",    int'(dispensed), 1);
        checkOutput("s3_remaining",    int'(remaining), 4);

        $display("[TB] scenario 4: start while busy, cancel on last tick");
        clearCounts();
        applyStimulus(1, 2, 0, 1, 1);
        applyStimulus(0, 0, 0, 1, 3);
        applyStimulus(1, 7, 0, 1, 1);
        applyStimulus(0, 0, 0, 1, 5);
        applyStimulus(0, 0, 1, 1, 1);
        applyStimulus(0, 0, 0, 1, 6);
        checkOutput("s4_valve_cycles", valveCnt, 13);
        checkOutput("s4_pump_cycles",  pumpCnt,  8);
        checkOutput("s4_done_pulses",  doneCnt,  1);
        checkOutput("s4_abort_pulses", abortCnt, 0);
        checkOutput("s4_dispensed",    int'(dispensed), 2);
        checkOutput("s4_remaining",    int'(remaining), 0);

        $display("[TB] scenario 5: back-to-back");
        clearCounts();
        applyStimulus(1, 1, 0, 1, 1);
        applyStimulus(0, 0, 0, 1, 9);
        applyStimulus(1, 2, 0, 1, 1);
        checkOutput("s5_no_gap_valve", int'(valve_open), 1);
        applyStimulus(0, 0, 0, 1, 16);
        checkOutput("s5_valve_cycles", valveCnt, 22);
        checkOutput("s5_done_pulses",  doneCnt,  2);
        checkOutput("s5_dispensed",    int'(dispensed), 2);

        $display("[TB] scenario 6: reset mid-operation");
        clearCounts();
        applyStimulus(1, 3, 0, 1, 1);
        applyStimulus(0, 0, 0, 1, 4);
        applyStimulus(1, 5, 0, 0, 1);
        checkOutput("s6_reset_valve", int'(valve_open), 0);
        checkOutput("s6_reset_pump",  int'(pump_on),    0);
        checkOutput("s6_reset_disp",  int'(dispensed),  0);
        applyStimulus(1, 5, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 2);
        checkOutput("s6_reset_pulses", doneCnt + abortCnt, 0);
        checkOutput("s6_reset_busy",   int'(busy), 0);
        clearCounts();
        applyStimulus(1, 1, 0, 1, 1);
        applyStimulus(0, 0, 0, 1, 12);
        checkOutput("s6_valve_cycles", valveCnt, 9);
        checkOutput("s6_pump_cycles",  pumpCnt,  4);
        checkOutput("s6_done_pulses",  doneCnt,  1);
        checkOutput("s6_dispensed",    int'(dispensed), 1);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule

// File: doc/dispense_sequencer.md
# dispense_sequencer

Sequences one dispense cycle for the water dispenser's outlet. Once the user confirms a volume, it accepts a start request with that volume in whole units and drives the valve and pump. It primes the line, pours the requested number of units on a fixed cycle-per-unit time base, then drains the line. A cancel stops the pour early, and the block reports completion or abort through one-cycle pulses.

## Interface

- AMOUNT_WIDTH, 8: width of the amount and progress counters, in units.
- TICKS_PER_UNIT, 50: clock cycles of pumping per unit; must be at least 1.
- PRIME_CYCLES, 4: cycles the valve is open with the pump off before pouring; must be at least 1.
- CLOSE_CYCLES, 4: cycles the valve stays open with the pump off after pouring; must be at least 1.

- clock  in  1  system clock; everything samples on the rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  dispense request; sampled every cycle.
- amount  in  AMOUNT_WIDTH  units to dispense; latched when a start is accepted.
- cancel  in  1  abort request; level or pulse.
- valve_open  out  1  outlet valve drive.
- pump_on  out  1  pump drive.
- busy  out  1  a sequence is in progress.
- done  out  1  one-cycle pulse: the sequence completed normally.
- aborted  out  1  one-cycle pulse: the sequence ended because of a cancel.
- dispensed  out  AMOUNT_WIDTH  units fully poured in the current or last sequence.
- remaining  out  AMOUNT_WIDTH  units still to pour in the current or last sequence.

## Operation

- All outputs are registered.
- When reset is 0 at an edge, every output clears to 0 on the next cycle and the FSM goes to IDLE. This applies in any state and takes priority over all other inputs. No pulse is emitted.
- The FSM has four states: IDLE, PRIME, POUR and CLOSE.
- IDLE: valve_open, pump_on and busy are 0.
  - The block accepts a start only when amount is nonzero.
  - On acceptance: latch remaining = amount, set dispensed = 0, clear the abort flag, go to PRIME.
  - A start with amount = 0 is ignored; no pulse is produced.
  - cancel is ignored in IDLE. If start and cancel arrive together in IDLE, the start is accepted.
- PRIME: valve_open = 1, busy = 1. After PRIME_CYCLES cycles, go to POUR.
- POUR: valve_open = 1, pump_on = 1, busy = 1.
  - A tick counter runs from 0 to TICKS_PER_UNIT-1.
  - At the terminal tick: dispensed increments, remaining decrements, and the tick counter wraps.
  - When remaining reaches 0, go to CLOSE.
- CLOSE: valve_open = 1, pump_on = 0, busy = 1. After CLOSE_CYCLES cycles, go to IDLE.
  - On that exit, pulse aborted if the abort flag is set; otherwise pulse done.
- cancel seen in PRIME or POUR sets the abort flag and forces CLOSE on the next edge.
  - Any partial unit is discarded; dispensed and remaining hold their values at that point.
- cancel in CLOSE is ignored.
- If cancel coincides with the terminal tick of the last unit, completion wins: the unit is counted and the sequence ends with done, not aborted.
- start while busy is ignored, and amount is not re-latched.
- dispensed and remaining hold after the sequence ends, until the next accepted start or reset.
- Invariant: while busy, dispensed + remaining equals the latched amount.
- Counters never wrap. The maximum amount is 2^AMOUNT_WIDTH − 1.

## Timing

- A start accepted at edge N makes busy and valve_open 1 from cycle N+1.
- pump_on rises at cycle N+1+PRIME_CYCLES and stays high for exactly amount × TICKS_PER_UNIT cycles.
- valve_open stays high for exactly PRIME_CYCLES + amount × TICKS_PER_UNIT + CLOSE_CYCLES cycles. busy is high for exactly the same cycles.
- done or aborted is high for one cycle: the first cycle after busy falls. busy is 0 during that cycle.
- A start presented during that pulse cycle is accepted, so sequences can run back to back with no gap cycle.
- dispensed updates on the cycle after each terminal tick.
- cancel sampled at edge M in PRIME or POUR: pump_on is 0 from cycle M+1, and valve_open stays high for CLOSE_CYCLES more cycles.

## Test plan

All scenarios use TICKS_PER_UNIT = 4, PRIME_CYCLES = 2, CLOSE_CYCLES = 3.

1. **Normal dispense.** start with amount = 3 → valve_open high 17 cycles, pump_on high 12 cycles, dispensed steps 1, 2, 3 every 4 cycles, remaining ends at 0, one done pulse, aborted stays 0.
2. **Zero amount.** start with amount = 0 → no output changes, no pulse.
3. **Cancel mid-pour.** amount = 5; cancel 6 cycles into POUR → pump_on 0 on the next cycle, valve_open high 3 more cycles, aborted pulse, dispensed = 1, remaining = 4 held.
4. **Start while busy, cancel on last tick.** amount = 2; start with amount = 7 pulsed during POUR → ignored, latched amount unchanged. Then cancel on the final terminal tick → dispensed = 2, done pulses, aborted stays 0.
5. **Back-to-back.** amount = 1; start with amount = 2 asserted in the done cycle → valve_open rises the next cycle with no idle gap; second sequence runs 13 cycles of valve_open.
6. **Reset mid-operation.** reset = 0 for 2 cycles during POUR, with start held → all outputs 0 on the cycle after the first low sample, no pulse. After release, start with amount = 1 runs a clean 9-cycle sequence.
